dsp_counter_terminal_count: RTL and testbench
=============================================

Name: dsp_counter_terminal_count

Overview:
- Enable-gated up-counter that flags when a terminal count has been reached. Intended for DSP48 mapping; 48-bit datapath.
- Used in the L1 trigger path as the trigger-rate sampling timer. It counts aclk cycles (TRIGGER_CLOCKS, e.g. 375000000 = 1 s at 375 MHz) and halts.
- Also usable as a free-running wrapping divider, with the terminal count either fixed by parameter or supplied at runtime.

Parameters:
- FIXED_TCOUNT, "TRUE". "TRUE": terminal count = FIXED_TCOUNT_VALUE and tcount_i is ignored. "FALSE": terminal count = tcount_i.
- FIXED_TCOUNT_VALUE, 375000000. Terminal count when fixed. Legal range 1 .. 2^48-1.
- HALT_AT_TCOUNT, "TRUE". "TRUE": counter freezes at terminal and the flag holds until reset. "FALSE": counter wraps to 0 and the flag is a 1-cycle pulse.

Ports:
- clk_i, input, 1: sole clock. All logic is on the rising edge.
- rst_i, input, 1: reset. Synchronous, active-high.
- count_i, input, 1: count enable. The counter advances by 1 on each clock where this is high (subject to halt).
- tcount_i, input, 48: runtime terminal count. Used only when FIXED_TCOUNT="FALSE". Sampled every clock; legal range 1 .. 2^48-1.
- count_o, output, 48: current counter value (registered).
- tcount_reached_o, output, 1: terminal-count flag (registered).

Behaviour:
Terminal count
- TC = FIXED_TCOUNT_VALUE when FIXED_TCOUNT="TRUE", else tcount_i.
- Comparison is against TC-1 (the count value before the final increment).

Reset
- When rst_i=1 at a clock edge: count_o <= 0 and tcount_reached_o <= 0.
- Reset has priority over count_i and over the terminal compare.
- Reset mid-count restarts from 0 with no pulse emitted.

Counting, HALT_AT_TCOUNT="TRUE"
- If count_i=1 and tcount_reached_o=0:
  - count_o <= count_o+1.
  - If count_o == TC-1, also tcount_reached_o <= 1.
- Once tcount_reached_o=1:
  - count_o stays at TC regardless of count_i.
  - tcount_reached_o stays 1 until rst_i.
- count_i=0: count_o holds.

Counting, HALT_AT_TCOUNT="FALSE"
- If count_i=1 and count_o == TC-1: count_o <= 0 and tcount_reached_o <= 1.
- Else if count_i=1: count_o <= count_o+1 and tcount_reached_o <= 0.
- Else: count_o holds and tcount_reached_o <= 0.
- The flag is therefore a single-cycle pulse every TC enabled cycles.

Latency
- tcount_reached_o rises on the clock edge that performs the TC-th enabled increment.
- It is visible in the cycle immediately after the clock with the TC-th count_i=1.
- With continuous count_i starting the cycle after reset, the flag is high starting TC clocks after reset deassertion.

Boundary conditions
- TC=1: the first enabled cycle sets the flag. In wrap mode this gives a pulse on every enabled cycle, and count_o stays at 0.
- Gaps in count_i stretch the timing but do not lose counts.
- Runtime TC change to a value ≤ current count_o (FIXED="FALSE"): no match occurs until the 48-bit counter wraps past 2^48-1 to 0. This is accepted behaviour and is not guarded.
- 48-bit overflow (only reachable as described above) wraps to 0 silently.

Power-up
- Registers initialise to 0, matching the reset state, so no reset is required before first use.

Implementation
- Compare and increment are 48-bit and map to a single DSP48 (pattern detect allowed).
- No combinational path from any input to any output.

Test Plan:
1. Fixed TC=5, HALT="TRUE": rst_i for 1 cycle, then count_i=1 continuously → count_o reads 1,2,3,4,5; tcount_reached_o goes high with count_o=5 and stays high; count_o remains 5 for a further 20 cycles.
2. Same configuration, count_i toggled 1,0,1,0,… → flag rises after the 5th enabled cycle (9 clocks after the first enable); count_o holds during the low cycles.
3. Fixed TC=4, HALT="FALSE", continuous count_i → count_o sequence 1,2,3,0,1,2,3,0…; tcount_reached_o is a 1-cycle pulse coinciding with each count_o=0, with a period of 4 clocks.
4. Reset mid-operation: TC=5 halt mode, assert rst_i at count_o=3 together with count_i=1 → next cycle count_o=0 and flag=0. Then assert rst_i while the flag is high → flag clears the next cycle.
5. FIXED="FALSE", HALT="FALSE", tcount_i=3 → pulse every 3 enabled cycles. Change tcount_i to 6 while count_o=1 → the next pulse occurs when count_o would reach 6 (5 more enabled cycles).
6. TC=1 in both halt modes:
   - Halt mode: the first enabled cycle sets the flag permanently, with count_o=1.
   - Wrap mode: the flag equals count_i delayed by one cycle, and count_o stays 0.

Source files
------------

// File: rtl/dsp_counter_terminal_count.sv
// Enable-gated 48-bit up-counter with a registered terminal-count flag.
// Either halts at the terminal count or wraps and pulses the flag.
module dsp_counter_terminal_count #(
  parameter string       FIXED_TCOUNT       = "TRUE",
  parameter logic [47:0] FIXED_TCOUNT_VALUE = 48'd375000000,
  parameter string       HALT_AT_TCOUNT     = "TRUE"
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_i,
  input  logic [47:0] tcount_i,
  output logic [47:0] count_o,
  output logic        tcount_reached_o
);

  localparam bit FixedTc = (FIXED_TCOUNT == "TRUE");
  localparam bit HaltTc  = (HALT_AT_TCOUNT == "TRUE");

  // Power-up values match the reset state so no reset is needed before first use.
  logic [47:0] count_q   = '0;
  logic        reached_q = 1'b0;
  logic [47:0] count_d;
  logic        reached_d;

  logic [47:0] termCount;
  logic [47:0] termMinus1;
  logic        atTerm;

  // Matching against TC-1 lets the flag register alongside the final increment.
  assign termCount  = FixedTc ? FIXED_TCOUNT_VALUE : tcount_i;
  assign termMinus1 = termCount - 48'd1;
  assign atTerm     = (count_q == termMinus1);

  always_comb begin
    count_d   = count_q;
    reached_d = reached_q;
    if (HaltTc) begin
      if (count_i && !reached_q) begin
        count_d = count_q + 48'd1;
        if (atTerm) begin
          reached_d = 1'b1;
        end
      end
    end else begin
      reached_d = 1'b0;
      if (count_i) begin
        if (atTerm) begin
          count_d   = '0;
          reached_d = 1'b1;
        end else begin
          count_d = count_q + 48'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      reached_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reached_q <= reached_d;
    end
  end

  assign count_o          = count_q;
  assign tcount_reached_o = reached_q;

endmodule

// File: tb/tb_dsp_counter_terminal_count.sv
// Scoreboard bench: directed vectors push hand-computed expectations,
// a monitor pops one per clock and compares against the selected instance.
module tb_dsp_counter_terminal_count;

  typedef struct {
    int          testId;
    int          dutSel;
    logic [47:0] expCount;
    logic        expFlag;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        cnt;
  logic [47:0] tc;

  logic [47:0] count0, count1, count2, count3;
  logic        flag0, flag1, flag2, flag3;

  expect_t expQ[$];
  int total = 0;
  int bad   = 0;
  int curTest = 0;

  // dut0: fixed TC=5 halt; dut1: fixed TC=4 wrap; dut2: runtime wrap; dut3: runtime halt
  dsp_counter_terminal_count #(.FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(48'd5),
                               .HALT_AT_TCOUNT("TRUE")) dut0 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt), .tcount_i(tc),
    .count_o(count0), .tcount_reached_o(flag0));

  dsp_counter_terminal_count #(.FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(48'd4),
                               .HALT_AT_TCOUNT("FALSE")) dut1 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt), .tcount_i(tc),
    .count_o(count1), .tcount_reached_o(flag1));

  dsp_counter_terminal_count #(.FIXED_TCOUNT("FALSE"), .FIXED_TCOUNT_VALUE(48'd1),
                               .HALT_AT_TCOUNT("FALSE")) dut2 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt), .tcount_i(tc),
    .count_o(count2), .tcount_reached_o(flag2));

  dsp_counter_terminal_count #(.FIXED_TCOUNT("FALSE"), .FIXED_TCOUNT_VALUE(48'd1),
                               .HALT_AT_TCOUNT("TRUE")) dut3 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt), .tcount_i(tc),
    .count_o(count3), .tcount_reached_o(flag3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs at the falling edge and record what the
  // selected instance must show after the following rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic [47:0] t,
                               input int sel, input logic [47:0] ec, input logic ef);
    expect_t e;
    @(negedge clk);
    rst = r;
    cnt = c;
    tc  = t;
    e.testId   = curTest;
    e.dutSel   = sel;
    e.expCount = ec;
    e.expFlag  = ef;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [47:0] actCount;
    logic        actFlag;
    case (e.dutSel)
      0:       begin actCount = count0; actFlag = flag0; end
      1:       begin actCount = count1; actFlag = flag1; end
      2:       begin actCount = count2; actFlag = flag2; end
      default: begin actCount = count3; actFlag = flag3; end
    endcase
    total++;
    if (actCount !== e.expCount || actFlag !== e.expFlag) begin
      bad++;
      $display("[TB] FAIL test%0d dut%0d: got count=%0d flag=%0b, expected count=%0d flag=%0b",
               e.testId, e.dutSel, actCount, actFlag, e.expCount, e.expFlag);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    int enabled;
    rst = 1'b0;
    cnt = 1'b0;
    tc  = 48'd5;

    // Test 1: fixed TC=5 halt, continuous enable, then hold for 20 cycles
    curTest = 1;
    applyStimulus(1, 0, 48'd5, 0, 48'd0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 48'd5, 0, 48'(i), (i == 5));
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 48'd5, 0, 48'd5, 1);

    // Test 2: alternating enable, flag after 5th enabled cycle (9 clocks)
    curTest = 2;
    applyStimulus(1, 0, 48'd5, 0, 48'd0, 0);
    enabled = 0;
    for (int j = 1; j <= 9; j++) begin
      if (j % 2 == 1) enabled++;
      applyStimulus(0, (j % 2 == 1), 48'd5, 0, 48'(enabled), (enabled == 5));
    end
    applyStimulus(0, 0, 48'd5, 0, 48'd5, 1);
    applyStimulus(0, 1, 48'd5, 0, 48'd5, 1);

    // Test 3: fixed TC=4 wrap, pulse coincides with count 0, period 4
    curTest = 3;
    applyStimulus(1, 0, 48'd5, 1, 48'd0, 0);
    for (int i = 1; i <= 12; i++) applyStimulus(0, 1, 48'd5, 1, 48'(i % 4), (i % 4 == 0));

    // Test 4: reset beats enable mid-count, and clears a held flag
    curTest = 4;
    applyStimulus(1, 0, 48'd5, 0, 48'd0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 48'd5, 0, 48'(i), 0);
    applyStimulus(1, 1, 48'd5, 0, 48'd0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 48'd5, 0, 48'(i), (i == 5));
    applyStimulus(0, 1, 48'd5, 0, 48'd5, 1);
    applyStimulus(1, 1, 48'd5, 0, 48'd0, 0);
    applyStimulus(0, 0, 48'd5, 0, 48'd0, 0);

    // Test 5: runtime TC=3 wrap, then switch to TC=6 at count 1
    curTest = 5;
    applyStimulus(1, 0, 48'd3, 2, 48'd0, 0);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1, 48'd3, 2, 48'(i % 3), (i % 3 == 0));
    for (int i = 2; i <= 5; i++) applyStimulus(0, 1, 48'd6, 2, 48'(i), 0);
    applyStimulus(0, 1, 48'd6, 2, 48'd0, 1);
    applyStimulus(0, 0, 48'd6, 2, 48'd0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 48'd6, 2, 48'(i), 0);
    applyStimulus(0, 1, 48'd6, 2, 48'd0, 1);

    // Test 6a: TC=1 halt, first enabled cycle latches flag with count 1
    curTest = 6;
    applyStimulus(1, 0, 48'd1, 3, 48'd0, 0);
    applyStimulus(0, 0, 48'd1, 3, 48'd0, 0);
    applyStimulus(0, 1, 48'd1, 3, 48'd1, 1);
    applyStimulus(0, 1, 48'd1, 3, 48'd1, 1);
    applyStimulus(0, 0, 48'd1, 3, 48'd1, 1);

    // Test 6b: TC=1 wrap, flag follows enable by one cycle, count stays 0
    curTest = 7;
    applyStimulus(1, 0, 48'd1, 2, 48'd0, 0);
    applyStimulus(0, 1, 48'd1, 2, 48'd0, 1);
    applyStimulus(0, 1, 48'd1, 2, 48'd0, 1);
    applyStimulus(0, 0, 48'd1, 2, 48'd0, 0);
    applyStimulus(0, 1, 48'd1, 2, 48'd0, 1);
    applyStimulus(0, 0, 48'd1, 2, 48'd0, 0);
    applyStimulus(0, 0, 48'd1, 2, 48'd0, 0);
    applyStimulus(0, 1, 48'd1, 2, 48'd0, 1);

    @(negedge clk);
    cnt = 1'b0;
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
